unsigned_oversample_expander: RTL and testbench
===============================================

Name: unsigned_oversample_expander

Overview:
- Widens a stream of narrow unsigned samples to a wider unsigned fixed-point format.
- Recovers sub-LSB precision by averaging 2^AVG_LOG2 consecutive samples (oversampling).
- Sits downstream of narrowing/rounding stages, for example in the ADC or dithered-quantizer return path. It restores fractional bits that those stages discarded.
- Streaming valid/ready on both sides; one wide result per block of 2^AVG_LOG2 accepted samples.

Parameters:
- DATA_WIDTH_IN, 8: width of the narrow unsigned input sample (> 0).
- DATA_WIDTH_OUT, 12: width of the wide unsigned output (>= DATA_WIDTH_IN).
- AVG_LOG2, 2: log2 of the number of samples averaged per output (0..16).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous active-high reset.
- clear  input  1  synchronous discard of the partial accumulation.
- s_valid  input  1  input sample valid.
- s_ready  output  1  block accepts the input sample.
- s_data  input  DATA_WIDTH_IN  unsigned narrow sample.
- m_valid  output  1  output result valid.
- m_ready  input  1  downstream accepts the result.
- m_data  output  DATA_WIDTH_OUT  unsigned wide averaged result.
- m_count_err  output  1  pulses for one cycle when clear discards a nonzero partial block.

Behaviour:
- Reset (synchronous, active-high):
  - m_valid=0, m_data=0, m_count_err=0.
  - Accumulator and sample counter = 0.
  - Reset has priority over all other inputs, including mid-block and while m_valid=1 (a pending result is dropped).
- Derived constants:
  - FRACWIDTH = DATA_WIDTH_OUT - DATA_WIDTH_IN.
  - SUMWIDTH = DATA_WIDTH_IN + AVG_LOG2.
  - SHIFT = FRACWIDTH - AVG_LOG2 (signed).
- Input handshake:
  - Transfer occurs when s_valid && s_ready.
  - s_ready = !m_valid || m_ready. The input stalls only while a completed result is waiting.
- Accumulation:
  - acc (SUMWIDTH bits) += s_data on each transfer.
  - cnt (AVG_LOG2 bits) increments and wraps at 2^AVG_LOG2.
  - The transfer with cnt == 2^AVG_LOG2-1 is the last sample of a block.
- Result formation, combinational on sum = acc + s_data of the last sample:
  - SHIFT >= 0: result = sum << SHIFT, zero-filled.
  - SHIFT < 0: drop -SHIFT LSBs with round-half-to-even. Round up if the dropped bits exceed half, or equal half and the kept LSB is 1.
  - Saturate to all-ones if rounding carries out. Analytically this is unreachable; the guard is still implemented.
- Latency:
  - The result is registered into m_data with m_valid=1 on the clock edge that accepts the last sample (visible the next cycle).
  - acc and cnt reset to 0 on that same edge.
- Output handshake:
  - m_data is held stable while m_valid && !m_ready.
  - On m_valid && m_ready, m_valid clears unless a new last sample is accepted the same cycle. In that case the new result loads and m_valid stays 1 (back-to-back, full throughput).
- AVG_LOG2 = 0: every accepted sample is a last sample; cnt is absent. Result = s_data << FRACWIDTH, latency 1.
- clear:
  - Zeroes acc and cnt.
  - A sample presented in the same cycle is discarded, and s_ready is still driven normally.
  - clear does not affect a pending m_valid/m_data.
  - m_count_err=1 the following cycle if cnt != 0 or a sample was discarded.
- Elaboration check: $error if DATA_WIDTH_IN <= 0, DATA_WIDTH_OUT < DATA_WIDTH_IN, or AVG_LOG2 is out of range.

Decomposition:
- Shared package numbers_pkg:
  - Function for SUMWIDTH/SHIFT computation.
  - Generic round-half-to-even helper constants (half-LSB mask).
- One combinational sub-module, unsigned_rhte_shift:
  - Parameters WIDTH_IN, WIDTH_OUT, SHIFT.
  - Performs left shift or round-half-to-even right shift with saturation.
  - Reusable by other width-change blocks.

Test Plan:
- Defaults (8/12/2), samples 10,11,11,10 back-to-back, m_ready=1 -> one result m_data=168 (0x0A8) one cycle after the 4th transfer; m_valid high exactly 1 cycle.
- Defaults, four samples of 255 -> m_data=4080 (0xFF0); four samples of 0 -> m_data=0.
- DATA_WIDTH_OUT=10, AVG_LOG2=6 (SHIFT=-4):
  - 64-sample blocks with sums 24, 40, 56 -> m_data = 2 (1.5 rounds to even 2), 2 (2.5 rounds to 2), 4 (3.5 rounds to 4).
  - All 255 -> 1020.
- Backpressure: m_ready=0 for 5 cycles after a result -> s_ready=0, m_data stable, no samples lost. Release m_ready -> next block result correct. With m_ready=1, continuous s_valid produces one result every 4 cycles.
- clear after 2 samples of a block -> m_count_err pulses once. The next 4 samples of 20 give m_data=320, uncorrupted.
- rst asserted mid-block and with m_valid=1 pending -> next cycle m_valid=0, m_data=0. The following block averages correctly from empty.

Source files
------------

// File: rtl/numbers_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : numbers_pkg
//  Description : Shared width/shift arithmetic and rounding helpers used by
//                width-change blocks.
//  Revision    : 1.0 - initial release
// ============================================================================
package numbers_pkg;

   // Widest dropped-bit field the half-LSB helper can describe
   localparam int MAX_MASK_WIDTH = 64;

   // Width of an accumulator holding 2^avg_log2 samples of width data_in
   function automatic int sum_width(input int data_in, input int avg_log2);
      return data_in + avg_log2;
   endfunction

   // Signed alignment shift from the accumulator to the output format
   function automatic int shift_amt(input int data_in, input int data_out, input int avg_log2);
      return (data_out - data_in) - avg_log2;
   endfunction

   // Pattern equal to exactly one half LSB of the kept field, given the
   // number of dropped bits (caller truncates to the dropped width)
   function automatic logic [MAX_MASK_WIDTH-1:0] half_lsb_mask(input int drop);
      return (drop > 0) ? (64'd1 << (drop - 1)) : 64'd0;
   endfunction

endpackage
`default_nettype wire

// File: rtl/unsigned_rhte_shift.sv
`default_nettype none
// ============================================================================
//  Module      : unsigned_rhte_shift
//  Description : Combinational unsigned rescale. Left shift with zero fill,
//                or right shift with round-half-to-even; saturates to all
//                ones if the result does not fit WIDTH_OUT.
//  Revision    : 1.0 - initial release
// ============================================================================
module unsigned_rhte_shift
   import numbers_pkg::*;
#(
   parameter int WIDTH_IN  = 10,
   parameter int WIDTH_OUT = 12,
   parameter int SHIFT     = 2
) (
   input  logic [WIDTH_IN-1:0]  i_data,
   output logic [WIDTH_OUT-1:0] o_data
);

   localparam int C_DROP = (SHIFT < 0) ? -SHIFT : 0;
   localparam int C_KEEP = (SHIFT < 0) ? (WIDTH_IN - C_DROP) : (WIDTH_IN + SHIFT);
   // One spare bit catches the carry out of rounding
   localparam int C_RW   = C_KEEP + 1;

   logic [C_RW-1:0] w_rounded;

   if (C_KEEP < 1 || C_DROP > MAX_MASK_WIDTH) begin : g_param_check
      $error("unsigned_rhte_shift: right shift drops every input bit or exceeds mask width");
   end

   if (SHIFT >= 0) begin : g_left
      assign w_rounded = C_RW'(i_data) << SHIFT;
   end else begin : g_right
      logic [C_KEEP-1:0] w_kept;
      logic [C_DROP-1:0] w_drop;
      logic [C_DROP-1:0] w_half;
      logic              w_round_up;

      assign w_kept     = i_data[WIDTH_IN-1:C_DROP];
      assign w_drop     = i_data[C_DROP-1:0];
      assign w_half     = C_DROP'(half_lsb_mask(C_DROP));
      // Above half always rounds up; exactly half rounds toward the even neighbour
      assign w_round_up = (w_drop > w_half) || ((w_drop == w_half) && w_kept[0]);
      assign w_rounded  = {1'b0, w_kept} + C_RW'(w_round_up);
   end

   if (C_RW > WIDTH_OUT) begin : g_sat
      assign o_data = (|w_rounded[C_RW-1:WIDTH_OUT]) ? {WIDTH_OUT{1'b1}}
                                                     : w_rounded[WIDTH_OUT-1:0];
   end else begin : g_ext
      assign o_data = WIDTH_OUT'(w_rounded);
   end

endmodule
`default_nettype wire

// File: rtl/unsigned_oversample_expander.sv
`default_nettype none
// ============================================================================
//  Module      : unsigned_oversample_expander
//  Description : Averages blocks of 2^AVG_LOG2 narrow unsigned samples and
//                emits one wider unsigned fixed-point result per block,
//                recovering sub-LSB precision. Valid/ready on both sides.
//  Revision    : 1.0 - initial release
// ============================================================================
module unsigned_oversample_expander
   import numbers_pkg::*;
#(
   parameter int DATA_WIDTH_IN  = 8,
   parameter int DATA_WIDTH_OUT = 12,
   parameter int AVG_LOG2       = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      s_valid,
   output logic                      s_ready,
   input  logic [DATA_WIDTH_IN-1:0]  s_data,
   output logic                      m_valid,
   input  logic                      m_ready,
   output logic [DATA_WIDTH_OUT-1:0] m_data,
   output logic                      m_count_err
);

   localparam int C_SUM_WIDTH = sum_width(DATA_WIDTH_IN, AVG_LOG2);
   localparam int C_SHIFT     = shift_amt(DATA_WIDTH_IN, DATA_WIDTH_OUT, AVG_LOG2);

   if (DATA_WIDTH_IN <= 0 || DATA_WIDTH_OUT < DATA_WIDTH_IN ||
       AVG_LOG2 < 0 || AVG_LOG2 > 16) begin : g_param_check
      $error("unsigned_oversample_expander: illegal parameter combination");
   end

   logic [C_SUM_WIDTH-1:0]    acc_q, acc_d;
   logic                      m_valid_q, m_valid_d;
   logic [DATA_WIDTH_OUT-1:0] m_data_q, m_data_d;
   logic                      count_err_q, count_err_d;

   logic                      w_s_ready;
   logic                      w_xfer;
   logic                      w_cnt_last;
   logic                      w_cnt_nz;
   logic                      w_last_xfer;
   logic [C_SUM_WIDTH-1:0]    w_sum;
   logic [DATA_WIDTH_OUT-1:0] w_result;

   // Input only stalls while a finished result is still waiting downstream
   assign w_s_ready   = !m_valid_q || m_ready;
   // A sample presented alongside clear is discarded, not accumulated
   assign w_xfer      = s_valid && w_s_ready && !clear;
   assign w_last_xfer = w_xfer && w_cnt_last;
   assign w_sum       = acc_q + C_SUM_WIDTH'(s_data);

   if (AVG_LOG2 > 0) begin : g_cnt
      logic [AVG_LOG2-1:0] cnt_q, cnt_d;

      // Sample position within the block; wraps naturally after the last one
      always_comb begin
         cnt_d = cnt_q;
         if (clear) begin
            cnt_d = '0;
         end else if (w_xfer) begin
            cnt_d = cnt_q + AVG_LOG2'(1);
         end
      end

      // Counter register
      always_ff @(posedge clk) begin
         if (rst) cnt_q <= '0;
         else     cnt_q <= cnt_d;
      end

      assign w_cnt_last = &cnt_q;
      assign w_cnt_nz   = |cnt_q;
   end else begin : g_no_cnt
      assign w_cnt_last = 1'b1;
      assign w_cnt_nz   = 1'b0;
   end

   unsigned_rhte_shift #(
      .WIDTH_IN  (C_SUM_WIDTH),
      .WIDTH_OUT (DATA_WIDTH_OUT),
      .SHIFT     (C_SHIFT)
   ) u_rescale (
      .i_data (w_sum),
      .o_data (w_result)
   );

   // Accumulate, close blocks into the output register, and flag discards
   always_comb begin
      acc_d       = acc_q;
      m_valid_d   = m_valid_q;
      m_data_d    = m_data_q;
      count_err_d = 1'b0;
      if (clear) begin
         acc_d       = '0;
         count_err_d = w_cnt_nz || (s_valid && w_s_ready);
      end else if (w_xfer) begin
         acc_d = w_cnt_last ? '0 : w_sum;
      end
      if (w_last_xfer) begin
         m_valid_d = 1'b1;
         m_data_d  = w_result;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   // State registers; reset drops any pending result
   always_ff @(posedge clk) begin
      if (rst) begin
         acc_q       <= '0;
         m_valid_q   <= 1'b0;
         m_data_q    <= '0;
         count_err_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         m_valid_q   <= m_valid_d;
         m_data_q    <= m_data_d;
         count_err_q <= count_err_d;
      end
   end

   assign s_ready     = w_s_ready;
   assign m_valid     = m_valid_q;
   assign m_data      = m_data_q;
   assign m_count_err = count_err_q;

endmodule
`default_nettype wire

// File: tb/tb_unsigned_oversample_expander.sv
`default_nettype none
// ============================================================================
//  Module      : tb_unsigned_oversample_expander
//  Description : Directed self-checking bench for the oversample expander,
//                default 8/12/2 instance plus an 8/10/6 rounding instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_unsigned_oversample_expander;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, clear;
   logic [7:0]  s_data;
   logic        s_valid, s_ready, m_valid, m_ready, m_count_err;
   logic [11:0] m_data;
   logic        s_valid6, s_ready6, m_valid6, m_ready6, m_count_err6;
   logic [9:0]  m_data6;

   int vectors     = 0;
   int miscompares = 0;

   unsigned_oversample_expander #(
      .DATA_WIDTH_IN (8), .DATA_WIDTH_OUT (12), .AVG_LOG2 (2)
   ) dut (
      .clk (clk), .rst (rst), .clear (clear),
      .s_valid (s_valid), .s_ready (s_ready), .s_data (s_data),
      .m_valid (m_valid), .m_ready (m_ready), .m_data (m_data),
      .m_count_err (m_count_err)
   );

   unsigned_oversample_expander #(
      .DATA_WIDTH_IN (8), .DATA_WIDTH_OUT (10), .AVG_LOG2 (6)
   ) dut6 (
      .clk (clk), .rst (rst), .clear (clear),
      .s_valid (s_valid6), .s_ready (s_ready6), .s_data (s_data),
      .m_valid (m_valid6), .m_ready (m_ready6), .m_data (m_data6),
      .m_count_err (m_count_err6)
   );

   // Inputs change on the falling edge; outputs are read on the next falling edge
   task automatic step(input logic v, input logic [7:0] d);
      s_valid = v;
      s_data  = d;
      @(negedge clk);
   endtask

   task automatic step6(input logic v, input logic [7:0] d);
      s_valid6 = v;
      s_data   = d;
      @(negedge clk);
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step(1'b0, 8'd0);
      step(1'b0, 8'd0);
      vectors++;
      if (m_valid !== 1'b0 || m_data !== 12'd0 || m_count_err !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: got v=%b d=%0d err=%b expected v=0 d=0 err=0", m_valid, m_data, m_count_err);
      end
      vectors++;
      if (m_valid6 !== 1'b0 || m_data6 !== 10'd0 || m_count_err6 !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state6: got v=%b d=%0d err=%b expected v=0 d=0 err=0", m_valid6, m_data6, m_count_err6);
      end
      rst = 1'b0;
      step(1'b0, 8'd0);
   endtask

   task automatic test_basic;
      m_ready = 1'b1;
      step(1'b1, 8'd10);
      step(1'b1, 8'd11);
      step(1'b1, 8'd11);
      vectors++;
      if (m_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_early_valid: got %b expected 0", m_valid);
      end
      step(1'b1, 8'd10);
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 12'd168) begin
         miscompares++;
         $display("FAIL basic_result: got v=%b d=%0d expected v=1 d=168", m_valid, m_data);
      end
      step(1'b0, 8'd0);
      vectors++;
      if (m_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL basic_valid_width: got %b expected 0", m_valid);
      end
   endtask

   task automatic test_extremes;
      for (int i = 0; i < 4; i++) step(1'b1, 8'd255);
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 12'd4080) begin
         miscompares++;
         $display("FAIL full_scale: got v=%b d=%0d expected v=1 d=4080", m_valid, m_data);
      end
      for (int i = 0; i < 4; i++) step(1'b1, 8'd0);
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 12'd0) begin
         miscompares++;
         $display("FAIL zero_scale: got v=%b d=%0d expected v=1 d=0", m_valid, m_data);
      end
      step(1'b0, 8'd0);
   endtask

   // 64-sample blocks: n ones then zeros gives sum n; sum/16 rounds half-to-even
   task automatic test_round;
      int          ones   [3] = '{24, 40, 56};
      logic [9:0]  expect6[3] = '{10'd2, 10'd2, 10'd4};
      m_ready6 = 1'b1;
      for (int b = 0; b < 3; b++) begin
         for (int i = 0; i < 64; i++) step6(1'b1, (i < ones[b]) ? 8'd1 : 8'd0);
         vectors++;
         if (m_valid6 !== 1'b1 || m_data6 !== expect6[b]) begin
            miscompares++;
            $display("FAIL round_sum%0d: got v=%b d=%0d expected v=1 d=%0d", ones[b], m_valid6, m_data6, expect6[b]);
         end
      end
      for (int i = 0; i < 64; i++) step6(1'b1, 8'd255);
      vectors++;
      if (m_valid6 !== 1'b1 || m_data6 !== 10'd1020) begin
         miscompares++;
         $display("FAIL round_full_scale: got v=%b d=%0d expected v=1 d=1020", m_valid6, m_data6);
      end
      step6(1'b0, 8'd0);
   endtask

   task automatic test_backpressure;
      logic exp_v;
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b1, 8'd5);
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 12'd80) begin
         miscompares++;
         $display("FAIL bp_result: got v=%b d=%0d expected v=1 d=80", m_valid, m_data);
      end
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'd7);
         vectors++;
         if (s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== 12'd80) begin
            miscompares++;
            $display("FAIL bp_stall%0d: got rdy=%b v=%b d=%0d expected rdy=0 v=1 d=80", i, s_ready, m_valid, m_data);
         end
      end
      m_ready = 1'b1;
      step(1'b1, 8'd7);
      vectors++;
      if (m_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL bp_release: got v=%b expected 0", m_valid);
      end
      for (int i = 0; i < 3; i++) step(1'b1, 8'd7);
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 12'd112) begin
         miscompares++;
         $display("FAIL bp_next_block: got v=%b d=%0d expected v=1 d=112", m_valid, m_data);
      end
      // Continuous stream: 1..4 sums to 10, 5..8 sums to 26
      for (int i = 0; i < 8; i++) begin
         step(1'b1, 8'(i + 1));
         exp_v = ((i % 4) == 3);
         vectors++;
         if (m_valid !== exp_v) begin
            miscompares++;
            $display("FAIL throughput_valid%0d: got %b expected %b", i, m_valid, exp_v);
         end
         if (exp_v) begin
            vectors++;
            if (m_data !== ((i == 3) ? 12'd40 : 12'd104)) begin
               miscompares++;
               $display("FAIL throughput_data%0d: got %0d expected %0d", i, m_data, (i == 3) ? 40 : 104);
            end
         end
      end
      step(1'b0, 8'd0);
   endtask

   task automatic test_clear;
      m_ready = 1'b1;
      clear   = 1'b1;
      step(1'b0, 8'd0);
      clear   = 1'b0;
      vectors++;
      if (m_count_err !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_empty_err: got %b expected 0", m_count_err);
      end
      step(1'b1, 8'd9);
      step(1'b1, 8'd9);
      clear = 1'b1;
      step(1'b1, 8'd9);
      clear = 1'b0;
      vectors++;
      if (m_count_err !== 1'b1 || m_valid !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_err_pulse: got err=%b v=%b expected err=1 v=0", m_count_err, m_valid);
      end
      step(1'b1, 8'd20);
      vectors++;
      if (m_count_err !== 1'b0) begin
         miscompares++;
         $display("FAIL clear_err_once: got %b expected 0", m_count_err);
      end
      for (int i = 0; i < 3; i++) step(1'b1, 8'd20);
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 12'd320) begin
         miscompares++;
         $display("FAIL clear_next_block: got v=%b d=%0d expected v=1 d=320", m_valid, m_data);
      end
      step(1'b0, 8'd0);
   endtask

   task automatic test_rst_mid;
      m_ready = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b1, 8'd50);
      rst = 1'b1;
      step(1'b0, 8'd0);
      rst = 1'b0;
      m_ready = 1'b0;
      for (int i = 0; i < 4; i++) step(1'b1, 8'd30);
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 12'd480) begin
         miscompares++;
         $display("FAIL rst_partial_flushed: got v=%b d=%0d expected v=1 d=480", m_valid, m_data);
      end
      rst = 1'b1;
      step(1'b0, 8'd0);
      rst = 1'b0;
      vectors++;
      if (m_valid !== 1'b0 || m_data !== 12'd0) begin
         miscompares++;
         $display("FAIL rst_pending_drop: got v=%b d=%0d expected v=0 d=0", m_valid, m_data);
      end
      m_ready = 1'b1;
      step(1'b1, 8'd1);
      step(1'b1, 8'd2);
      step(1'b1, 8'd3);
      step(1'b1, 8'd6);
      vectors++;
      if (m_valid !== 1'b1 || m_data !== 12'd48) begin
         miscompares++;
         $display("FAIL rst_next_block: got v=%b d=%0d expected v=1 d=48", m_valid, m_data);
      end
      step(1'b0, 8'd0);
   endtask

   initial begin
      rst      = 1'b1;
      clear    = 1'b0;
      s_valid  = 1'b0;
      s_valid6 = 1'b0;
      s_data   = 8'd0;
      m_ready  = 1'b1;
      m_ready6 = 1'b1;
      @(negedge clk);
      test_reset();
      test_basic();
      test_extremes();
      test_round();
      test_backpressure();
      test_clear();
      test_rst_mid();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
`default_nettype wire
